alu_resp_collector: RTL and testbench

- Hardware response side of the ALU stimulus/response packet protocol.
- Accepts a stimulus packet over a valid/ready handshake and drives its fields onto the ALU input pins.
- Waits the ALU's fixed pipeline latency, then samples the ALU outputs and compares them against the packet's expected fields.
- Emits a response packet with a PASS/FAIL bit over a valid/ready handshake and keeps running pass/fail counts. Sits between a packet source (ROM or host FIFO) and the ALU under test.

---
 rtl/alu_pkt_pkg.sv | 79 +++++++
 rtl/alu_pkt_unpack.sv | 41 ++++
 rtl/alu_resp_collector.sv | 187 ++++++++++++++++++
 tb/tb_alu_resp_collector.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkt_pkg.sv
// Shared definitions for the ALU stimulus/response packet protocol:
// packet widths, field offsets and the collector state encoding.
package alu_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  // Width helpers for any operand width n and command width m.
  function automatic int tc_w(input int n, input int m);
    return 19 + 4 * n + m;
  endfunction

  function automatic int cmp_w(input int n);
    return 2 * n + 6;
  endfunction

  function automatic int resp_w(input int n);
    return 8 + 2 * cmp_w(n) + 1;
  endfunction

  // LSB offsets of the fixed-position low fields of stim_pkt.
  localparam int ERR_OFF     = 0;
  localparam int OV_OFF      = 1;
  localparam int EGL_OFF     = 2;
  localparam int COUT_OFF    = 5;
  localparam int EXP_RES_OFF = 6;

  // LSB offsets of the fields whose position depends on n and m.
  function automatic int rsv_res_off(input int n);
    return n + 7;
  endfunction

  function automatic int mode_off(input int n);
    return 2 * n + 6;
  endfunction

  function automatic int ce_off(input int n);
    return 2 * n + 7;
  endfunction

  function automatic int cin_off(input int n);
    return 2 * n + 8;
  endfunction

  function automatic int cmd_off(input int n);
    return 2 * n + 9;
  endfunction

  function automatic int opb_off(input int n, input int m);
    return 2 * n + 9 + m;
  endfunction

  function automatic int opa_off(input int n, input int m);
    return 3 * n + 9 + m;
  endfunction

  function automatic int inp_valid_off(input int n, input int m);
    return 4 * n + 9 + m;
  endfunction

  function automatic int fid_off(input int n, input int m);
    return 4 * n + 11 + m;
  endfunction

  // Widths for the default 8-bit operand / 4-bit command build.
  localparam int N_DEF  = 8;
  localparam int M_DEF  = 4;
  localparam int TC_W   = 19 + 4 * N_DEF + M_DEF;
  localparam int CMP_W  = 2 * N_DEF + 6;
  localparam int RESP_W = 8 + 2 * CMP_W + 1;

  // Latency counter width; covers LAT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/alu_pkt_unpack.sv
// Combinational slicing of a stimulus packet into its named fields.
// Kept separate so stimulus generators can reuse the same field map.
module alu_pkt_unpack
  import alu_pkt_pkg::*;
#(
  parameter int n = 8,
  parameter int m = 4
) (
  input  logic [tc_w(n, m)-1:0] stim_pkt,
  output logic [7:0]            feature_id,
  output logic [1:0]            inp_valid,
  output logic [n-1:0]          opa,
  output logic [n-1:0]          opb,
  output logic [m-1:0]          cmd,
  output logic                  cin,
  output logic                  ce,
  output logic                  mode,
  output logic [n-2:0]          reserved_res,
  output logic [n:0]            expected_res,
  output logic                  cout,
  output logic [2:0]            egl,
  output logic                  ov,
  output logic                  err
);

  assign feature_id   = stim_pkt[fid_off(n, m) +: 8];
  assign inp_valid    = stim_pkt[inp_valid_off(n, m) +: 2];
  assign opa          = stim_pkt[opa_off(n, m) +: n];
  assign opb          = stim_pkt[opb_off(n, m) +: n];
  assign cmd          = stim_pkt[cmd_off(n) +: m];
  assign cin          = stim_pkt[cin_off(n)];
  assign ce           = stim_pkt[ce_off(n)];
  assign mode         = stim_pkt[mode_off(n)];
  assign reserved_res = stim_pkt[rsv_res_off(n) +: (n - 1)];
  assign expected_res = stim_pkt[EXP_RES_OFF +: (n + 1)];
  assign cout         = stim_pkt[COUT_OFF];
  assign egl          = stim_pkt[EGL_OFF +: 3];
  assign ov           = stim_pkt[OV_OFF];
  assign err          = stim_pkt[ERR_OFF];

endmodule

// File: rtl/alu_resp_collector.sv
// Response side of the ALU stimulus/response protocol: accepts a packet,
// drives it onto the ALU pins, waits the ALU latency, compares the ALU
// outputs with the packet's expected fields and emits a PASS/FAIL response.
module alu_resp_collector
  import alu_pkt_pkg::*;
#(
  parameter int n     = 8,
  parameter int m     = 4,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   stim_valid,
  output logic                   stim_ready,
  input  logic [tc_w(n, m)-1:0]  stim_pkt,
  output logic [n-1:0]           alu_opa,
  output logic [n-1:0]           alu_opb,
  output logic [m-1:0]           alu_cmd,
  output logic [1:0]             alu_in_val,
  output logic                   alu_cin,
  output logic                   alu_ce,
  output logic                   alu_mode,
  input  logic [2*n-1:0]         alu_res,
  input  logic                   alu_cout,
  input  logic                   alu_of,
  input  logic                   alu_err,
  input  logic [2:0]             alu_egl,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [resp_w(n)-1:0]   resp_pkt,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt
);

  localparam int               CW       = cmp_w(n);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT - 1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept;

  logic [7:0]        pk_feature_id;
  logic [1:0]        pk_inp_valid;
  logic [n-1:0]      pk_opa;
  logic [n-1:0]      pk_opb;
  logic [m-1:0]      pk_cmd;
  logic              pk_cin;
  logic              pk_ce;
  logic              pk_mode;
  logic [n-2:0]      pk_reserved_res;
  logic [n:0]        pk_expected_res;
  logic              pk_cout;
  logic [2:0]        pk_egl;
  logic              pk_ov;
  logic              pk_err;

  logic [7:0]        fid_hold;
  logic [CW-1:0]     exp_hold;
  logic [CW-1:0]     actual;
  logic              pass_bit;

  alu_pkt_unpack #(
    .n (n),
    .m (m)
  ) u_unpack (
    .stim_pkt     (stim_pkt),
    .feature_id   (pk_feature_id),
    .inp_valid    (pk_inp_valid),
    .opa          (pk_opa),
    .opb          (pk_opb),
    .cmd          (pk_cmd),
    .cin          (pk_cin),
    .ce           (pk_ce),
    .mode         (pk_mode),
    .reserved_res (pk_reserved_res),
    .expected_res (pk_expected_res),
    .cout         (pk_cout),
    .egl          (pk_egl),
    .ov           (pk_ov),
    .err          (pk_err)
  );

  assign accept = stim_valid && stim_ready;

  // The ALU result bus lines up with {reserved_res, expected_res}, so the
  // comparison is a flat bitwise equality over the whole 2n+6 field.
  assign actual   = {alu_res, alu_cout, alu_egl, alu_of, alu_err};
  assign pass_bit = (exp_hold == actual);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept, wait out the ALU latency, capture, hand off.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; ready is masked while reset is held so nothing is
  // advertised before the collector is live.
  always_comb begin
    stim_ready = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE:    stim_ready = RST_N;
      SEND:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Latency counter: loaded on accept, counts down to zero while waiting.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_cnt <= '0;
    end else if (accept) begin
      lat_cnt <= LAT_LOAD;
    end else if (state == WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // ALU input drive: loaded on accept and held until the next accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_opa    <= '0;
      alu_opb    <= '0;
      alu_cmd    <= '0;
      alu_in_val <= '0;
      alu_cin    <= 1'b0;
      alu_ce     <= 1'b0;
      alu_mode   <= 1'b0;
    end else if (accept) begin
      alu_opa    <= pk_opa;
      alu_opb    <= pk_opb;
      alu_cmd    <= pk_cmd;
      alu_in_val <= pk_inp_valid;
      alu_cin    <= pk_cin;
      alu_ce     <= pk_ce;
      alu_mode   <= pk_mode;
    end
  end

  // Packet fields needed at capture time; only meaningful after an accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      fid_hold <= pk_feature_id;
      exp_hold <= {pk_reserved_res, pk_expected_res, pk_cout, pk_egl, pk_ov, pk_err};
    end
  end

  // Capture: build the response and bump exactly one counter. The response
  // stays put through SEND, so backpressure cannot disturb it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_pkt <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (state == CAPTURE) begin
      resp_pkt <= {fid_hold, exp_hold, actual, pass_bit};
      if (pass_bit) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_collector.sv
// Directed bench for alu_resp_collector with a small adder model of the ALU
// whose result is only valid in the single cycle the collector should sample.
module tb_alu_resp_collector;

  localparam int LAT = 2;

  logic        CLK;
  logic        RST_N;

  logic        stim_valid;
  logic        stim_ready;
  logic [54:0] stim_pkt;
  logic [7:0]  alu_opa;
  logic [7:0]  alu_opb;
  logic [3:0]  alu_cmd;
  logic [1:0]  alu_in_val;
  logic        alu_cin;
  logic        alu_ce;
  logic        alu_mode;
  logic [15:0] alu_res;
  logic        resp_valid;
  logic        resp_ready;
  logic [52:0] resp_pkt;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;

  logic        stim_valid2;
  logic        stim_ready2;
  logic [54:0] stim_pkt2;
  logic [7:0]  alu_opa2;
  logic [7:0]  alu_opb2;
  logic [3:0]  alu_cmd2;
  logic [1:0]  alu_in_val2;
  logic        alu_cin2;
  logic        alu_ce2;
  logic        alu_mode2;
  logic [15:0] alu_res2;
  logic        resp_valid2;
  logic        resp_ready2;
  logic [52:0] resp_pkt2;
  logic [1:0]  pass_cnt2;
  logic [1:0]  fail_cnt2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          age;
  logic        inj;
  int          acc_cyc[$];
  logic [7:0]  resp_fid[$];

  alu_resp_collector #(.n(8), .m(4), .LAT(LAT), .CNT_W(16)) u_dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .stim_valid (stim_valid),
    .stim_ready (stim_ready),
    .stim_pkt   (stim_pkt),
    .alu_opa    (alu_opa),
    .alu_opb    (alu_opb),
    .alu_cmd    (alu_cmd),
    .alu_in_val (alu_in_val),
    .alu_cin    (alu_cin),
    .alu_ce     (alu_ce),
    .alu_mode   (alu_mode),
    .alu_res    (alu_res),
    .alu_cout   (1'b0),
    .alu_of     (1'b0),
    .alu_err    (1'b0),
    .alu_egl    (3'b000),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pkt   (resp_pkt),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt)
  );

  alu_resp_collector #(.n(8), .m(4), .LAT(1), .CNT_W(2)) u_dut2 (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .stim_valid (stim_valid2),
    .stim_ready (stim_ready2),
    .stim_pkt   (stim_pkt2),
    .alu_opa    (alu_opa2),
    .alu_opb    (alu_opb2),
    .alu_cmd    (alu_cmd2),
    .alu_in_val (alu_in_val2),
    .alu_cin    (alu_cin2),
    .alu_ce     (alu_ce2),
    .alu_mode   (alu_mode2),
    .alu_res    (alu_res2),
    .alu_cout   (1'b0),
    .alu_of     (1'b0),
    .alu_err    (1'b0),
    .alu_egl    (3'b000),
    .resp_valid (resp_valid2),
    .resp_ready (resp_ready2),
    .resp_pkt   (resp_pkt2),
    .pass_cnt   (pass_cnt2),
    .fail_cnt   (fail_cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU model: result valid only LAT cycles after the inputs were driven.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) age <= 1000;
    else if (stim_valid && stim_ready) age <= 0;
    else if (age < 1000) age <= age + 1;
  end

  assign alu_res  = (age == LAT) ? (16'(alu_opa) + 16'(alu_opb) + 16'(inj)) : 16'hDEAD;
  assign alu_res2 = 16'(alu_opa2) + 16'(alu_opb2);

  // Handshake monitor for spacing and ordering checks.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (stim_valid && stim_ready) acc_cyc.push_back(cyc);
    if (resp_valid && resp_ready) resp_fid.push_back(resp_pkt[52:45]);
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packet layout (LSB offsets for n=8, m=4): fid 47, inp_valid 45, opa 37,
  // opb 29, cmd 25, {cin,ce,mode} 22, expected_res 6.
  function automatic logic [54:0] make_pkt(input logic [7:0] fid, input logic [7:0] a,
                                           input logic [7:0] b, input logic [8:0] er,
                                           input logic [3:0] cmd, input logic [1:0] iv,
                                           input logic [2:0] ctl);
    logic [54:0] p;
    p = '0;
    p[47 +: 8] = fid;
    p[45 +: 2] = iv;
    p[37 +: 8] = a;
    p[29 +: 8] = b;
    p[25 +: 4] = cmd;
    p[22 +: 3] = ctl;
    p[6 +: 9]  = er;
    return p;
  endfunction

  function automatic logic [52:0] exp_resp(input logic [7:0] fid, input logic [15:0] er,
                                           input logic [15:0] ar, input logic p);
    return {fid, er, 6'b0, ar, 6'b0, p};
  endfunction

  // Called at a negedge with stim_valid high; returns at the negedge after the accept edge.
  task automatic do_accept(input string tag);
    int w;
    w = 0;
    while (!stim_ready && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk_eq({tag, " ready"}, 64'(stim_ready), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Counts negedges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [54:0] pk;
    logic seen;

    RST_N       = 1'b0;
    stim_valid  = 1'b0;
    stim_pkt    = '0;
    resp_ready  = 1'b0;
    inj         = 1'b0;
    stim_valid2 = 1'b0;
    stim_pkt2   = '0;
    resp_ready2 = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset state
    chk_eq("rst stim_ready", 64'(stim_ready), 64'd0);
    chk_eq("rst resp_valid", 64'(resp_valid), 64'd0);
    chk_eq("rst resp_pkt", 64'(resp_pkt), 64'd0);
    chk_eq("rst counters", 64'({pass_cnt, fail_cnt}), 64'd0);
    chk_eq("rst alu_opa", 64'(alu_opa), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk_eq("idle stim_ready", 64'(stim_ready), 64'd1);

    // Matching ALU
    resp_ready = 1'b1;
    stim_pkt   = make_pkt(8'h01, 8'h0F, 8'h01, 9'h010, 4'h0, 2'b00, 3'b000);
    stim_valid = 1'b1;
    do_accept("t1");
    stim_valid = 1'b0;
    chk_eq("t1 alu_opa", 64'(alu_opa), 64'h0F);
    chk_eq("t1 alu_opb", 64'(alu_opb), 64'h01);
    chk_eq("t1 busy ready", 64'(stim_ready), 64'd0);
    wait_resp(lat);
    chk_eq("t1 latency", 64'(lat), 64'(LAT + 2));
    chk_eq("t1 resp_pkt", 64'(resp_pkt), 64'(exp_resp(8'h01, 16'h0010, 16'h0010, 1'b1)));
    chk_eq("t1 pass_cnt", 64'(pass_cnt), 64'd1);
    chk_eq("t1 fail_cnt", 64'(fail_cnt), 64'd0);
    @(negedge CLK);
    chk_eq("t1 valid drop", 64'(resp_valid), 64'd0);
    chk_eq("t1 ready back", 64'(stim_ready), 64'd1);

    // Mismatching ALU
    inj        = 1'b1;
    stim_pkt   = make_pkt(8'h02, 8'h0F, 8'h01, 9'h010, 4'h0, 2'b00, 3'b000);
    stim_valid = 1'b1;
    do_accept("t2");
    stim_valid = 1'b0;
    wait_resp(lat);
    chk_eq("t2 pass bit", 64'(resp_pkt[0]), 64'd0);
    chk_eq("t2 actual res", 64'(resp_pkt[22:7]), 64'h0011);
    chk_eq("t2 expected res", 64'(resp_pkt[44:29]), 64'h0010);
    chk_eq("t2 fail_cnt", 64'(fail_cnt), 64'd1);
    chk_eq("t2 pass_cnt", 64'(pass_cnt), 64'd1);
    @(negedge CLK);
    inj = 1'b0;

    // Backpressure with a second packet waiting
    resp_ready = 1'b0;
    stim_pkt   = make_pkt(8'h03, 8'h20, 8'h05, 9'h025, 4'h0, 2'b00, 3'b000);
    stim_valid = 1'b1;
    do_accept("t3a");
    stim_pkt = make_pkt(8'h04, 8'h11, 8'h22, 9'h033, 4'h0, 2'b00, 3'b000);
    wait_resp(lat);
    for (int i = 0; i < 10; i++) begin
      chk_eq("t3 held pkt", 64'(resp_pkt), 64'(exp_resp(8'h03, 16'h0025, 16'h0025, 1'b1)));
      chk_eq("t3 held valid", 64'(resp_valid), 64'd1);
      chk_eq("t3 stim blocked", 64'(stim_ready), 64'd0);
      @(negedge CLK);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    chk_eq("t3 valid drop", 64'(resp_valid), 64'd0);
    chk_eq("t3 opa before 2nd", 64'(alu_opa), 64'h20);
    @(negedge CLK);
    stim_valid = 1'b0;
    chk_eq("t3 opa after 2nd", 64'(alu_opa), 64'h11);
    wait_resp(lat);
    chk_eq("t3b latency", 64'(lat), 64'(LAT + 2));
    chk_eq("t3b resp_pkt", 64'(resp_pkt), 64'(exp_resp(8'h04, 16'h0033, 16'h0033, 1'b1)));
    @(negedge CLK);
    chk_eq("t3 counters", 64'({pass_cnt, fail_cnt}), 64'({16'd3, 16'd1}));

    // Back-to-back with resp_ready held high
    acc_cyc.delete();
    resp_fid.delete();
    stim_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a  = 8'(i * 3 + 1);
      b  = 8'(i + 2);
      pk = make_pkt(8'(8'h10 + i), a, b, 9'(a) + 9'(b), 4'(i + 5), 2'(i), 3'(i + 1));
      stim_pkt = pk;
      do_accept("t4");
      chk_eq("t4 alu_cmd", 64'(alu_cmd), 64'(i + 5));
      chk_eq("t4 alu_in_val", 64'(alu_in_val), 64'(i));
      chk_eq("t4 cin/ce/mode", 64'({alu_cin, alu_ce, alu_mode}), 64'(i + 1));
    end
    stim_valid = 1'b0;
    wait_resp(lat);
    @(negedge CLK);
    chk_eq("t4 accepts", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      chk_eq("t4 spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LAT + 3));
    end
    chk_eq("t4 responses", 64'(resp_fid.size()), 64'd4);
    for (int i = 0; i < resp_fid.size(); i++) begin
      chk_eq("t4 fid order", 64'(resp_fid[i]), 64'(8'h10 + i));
    end
    chk_eq("t4 pass_cnt", 64'(pass_cnt), 64'd7);
    chk_eq("t4 fail_cnt", 64'(fail_cnt), 64'd1);

    // Reset pulse during WAIT
    stim_pkt   = make_pkt(8'h20, 8'h33, 8'h44, 9'h077, 4'hA, 2'b11, 3'b111);
    stim_valid = 1'b1;
    do_accept("t5");
    stim_valid = 1'b0;
    chk_eq("t5 opa driven", 64'(alu_opa), 64'h33);
    RST_N = 1'b0;
    #1;
    chk_eq("t5 rst resp_valid", 64'(resp_valid), 64'd0);
    chk_eq("t5 rst stim_ready", 64'(stim_ready), 64'd0);
    chk_eq("t5 rst alu pins", 64'({alu_opa, alu_opb, alu_cmd, alu_in_val, alu_cin, alu_ce, alu_mode}), 64'd0);
    chk_eq("t5 rst counters", 64'({pass_cnt, fail_cnt}), 64'd0);
    chk_eq("t5 rst resp_pkt", 64'(resp_pkt), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk_eq("t5 ready after rst", 64'(stim_ready), 64'd1);
    seen = 1'b0;
    repeat (LAT + 6) begin
      @(negedge CLK);
      seen = seen | resp_valid;
    end
    chk_eq("t5 no resp", 64'(seen), 64'd0);
    chk_eq("t5 counters stay", 64'({pass_cnt, fail_cnt}), 64'd0);

    // LAT=1, 2-bit counters: five passing packets saturate at 3
    for (int i = 0; i < 5; i++) begin
      int w;
      stim_pkt2   = make_pkt(8'(8'h30 + i), 8'h01, 8'h02, 9'h003, 4'h0, 2'b00, 3'b000);
      stim_valid2 = 1'b1;
      w = 0;
      while (!stim_ready2 && w < 100) begin
        @(negedge CLK);
        w++;
      end
      chk_eq("t6 ready", 64'(stim_ready2), 64'd1);
      @(posedge CLK);
      @(negedge CLK);
      stim_valid2 = 1'b0;
      w = 0;
      while (!resp_valid2 && w < 100) begin
        @(negedge CLK);
        w++;
      end
      chk_eq("t6 resp pass", 64'({resp_valid2, resp_pkt2[0]}), 64'd3);
      if (i == 2) chk_eq("t6 cnt at 3", 64'(pass_cnt2), 64'd3);
      @(negedge CLK);
    end
    chk_eq("t6 pass_cnt sat", 64'(pass_cnt2), 64'd3);
    chk_eq("t6 fail_cnt", 64'(fail_cnt2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
